// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debounces a synchronized level into a clean level, rise/fall pulses and a press count
// The four-state FSM, the stability counter and all outputs share one register block.
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int EVT_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sync,
    input  logic             i_clr_cnt,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_busy,
    output logic [EVT_W-1:0] o_press_cnt
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [EVT_W-1:0] PRESS_MAX = '1;
    localparam logic [EVT_W-1:0] PRESS_ONE = EVT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE_LOW;
            cnt         <= '0;
            o_level     <= 1'b0;
            o_rise      <= 1'b0;
            o_fall      <= 1'b0;
            o_press_cnt <= '0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (i_clr_cnt) begin
                o_press_cnt <= '0;
            end
            case (state)
                IDLE_LOW: begin
                    if (i_sync) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!i_sync) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_HIGH;
                        cnt     <= '0;
                        o_level <= 1'b1;
                        o_rise  <= 1'b1;
                        // A clear coinciding with a commit keeps that press.
                        if (i_clr_cnt) begin
                            o_press_cnt <= PRESS_ONE;
                        end else if (o_press_cnt != PRESS_MAX) begin
                            o_press_cnt <= o_press_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!i_sync) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (i_sync) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_LOW;
                        cnt     <= '0;
                        o_level <= 1'b0;
                        o_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - scoreboard bench for debounce_edge against a run-length reference model
module tb_debounce_edge;

    localparam int D     = 4;
    localparam int EVT_W = 8;
    localparam int PMAX  = (1 << EVT_W) - 1;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_sync;
    logic             i_clr_cnt;
    logic             o_level;
    logic             o_rise;
    logic             o_fall;
    logic             o_busy;
    logic [EVT_W-1:0] o_press_cnt;

    typedef struct packed {
        logic             level;
        logic             rise;
        logic             fall;
        logic             busy;
        logic [EVT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: debounced level plus the length of the current run of
    // samples that disagree with it; the level flips once that run reaches D.
    int m_level;
    int m_run;
    int m_cnt;

    debounce_edge #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16),
        .EVT_W          (EVT_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sync     (i_sync),
        .i_clr_cnt  (i_clr_cnt),
        .o_level    (o_level),
        .o_rise     (o_rise),
        .o_fall     (o_fall),
        .o_busy     (o_busy),
        .o_press_cnt(o_press_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_level = 0;
        m_run   = 0;
        m_cnt   = 0;
    endtask

    task automatic step(input logic s, input logic clr);
        exp_t e;
        @(negedge i_clk);
        i_sync    = s;
        i_clr_cnt = clr;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (clr) m_cnt = 0;
        if (int'(s) != m_level) m_run++;
        else m_run = 0;
        if (m_run == D) begin
            m_run   = 0;
            m_level = int'(s);
            if (s) begin
                e.rise = 1'b1;
                m_cnt  = (m_cnt < PMAX) ? m_cnt + 1 : PMAX;
            end else begin
                e.fall = 1'b1;
            end
        end
        e.level = (m_level != 0);
        e.busy  = (m_run > 0);
        e.cnt   = EVT_W'(m_cnt);
        exp_q.push_back(e);
        @(posedge i_clk);
    endtask

    task automatic run_of(input logic s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0);
    endtask

    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (o_level !== e.level || o_rise !== e.rise || o_fall !== e.fall ||
                o_busy !== e.busy || o_press_cnt !== e.cnt) begin
                errors++;
                $display("FAIL outputs t=%0t got lvl=%b rise=%b fall=%b busy=%b cnt=%0d exp lvl=%b rise=%b fall=%b busy=%b cnt=%0d",
                         $time, o_level, o_rise, o_fall, o_busy, o_press_cnt,
                         e.level, e.rise, e.fall, e.busy, e.cnt);
            end
            checks++;
            if (o_rise === 1'b1 && o_fall === 1'b1) begin
                errors++;
                $display("FAIL exclusive t=%0t got rise=1 fall=1 exp not both", $time);
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if (o_level !== 1'b0 || o_rise !== 1'b0 || o_fall !== 1'b0 ||
            o_busy !== 1'b0 || o_press_cnt !== '0) begin
            errors++;
            $display("FAIL %s got lvl=%b rise=%b fall=%b busy=%b cnt=%0d exp all zero",
                     name, o_level, o_rise, o_fall, o_busy, o_press_cnt);
        end
    endtask

    initial begin
        int total;
        i_sync    = 1'b0;
        i_clr_cnt = 1'b0;
        i_rst_n   = 1'b1;
        model_reset();
        #1 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #2 check_reset_outputs("reset_state");
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;

        // Clean press, then release.
        run_of(1'b0, 5);
        run_of(1'b1, 11);
        run_of(1'b0, 6);

        // Glitch: three highs must not commit.
        run_of(1'b1, 3);
        run_of(1'b0, 3);

        // Bounce then settle, followed by a clean release.
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        run_of(1'b1, 4);
        run_of(1'b0, 4);
        run_of(1'b0, 2);

        // Saturation, then clear coincident with a rise commit.
        for (int i = 0; i < 257; i++) begin
            run_of(1'b1, D);
            run_of(1'b0, D);
        end
        run_of(1'b1, D - 1);
        step(1'b1, 1'b1);
        run_of(1'b0, D);
        step(1'b0, 1'b1);

        // Bring the counter off zero, then reset mid WAIT_HIGH with cnt=2.
        run_of(1'b1, D);
        run_of(1'b0, D);
        run_of(1'b1, 2);
        #3 i_rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        run_of(1'b1, D + 2);
        run_of(1'b0, D);

        // Random runs of mixed length with occasional clears.
        total = 0;
        while (total < 10000) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) step(v, ($urandom_range(0, 63) == 0));
            total += len;
        end

        @(negedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
Downstream consumer of the two-flop input synchronizer. Takes an already-synchronized level, such as a push-button or slow external strobe. Produces three things: a debounced level, single-cycle rise and fall pulses, and a saturating count of debounced rising edges. It sits between the synchronizer output and control logic that needs clean, one-cycle events.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive sampling edges the input must hold a new value before o_level changes; legal range 2..65535
CNT_W, 16, width of the internal stability counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
EVT_W, 8, width of o_press_cnt

Ports:
i_clk  in  1  single system clock, rising-edge active
i_rst_n  in  1  asynchronous active-low reset
i_sync  in  1  synchronized input level from the synchronizer stage; treated as glitch-prone but metastability-free
i_clr_cnt  in  1  synchronous clear of o_press_cnt
o_level  out  1  debounced level, registered
o_rise  out  1  one-cycle pulse on debounced 0->1, registered
o_fall  out  1  one-cycle pulse on debounced 1->0, registered
o_busy  out  1  high while in a WAIT state (candidate transition in progress); decoded from the state register only
o_press_cnt  out  EVT_W  count of debounced rising edges, saturating

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low; assertion takes effect immediately, without a clock edge.
- Reset values: state=IDLE_LOW, stability counter=0, o_level=0, o_rise=0, o_fall=0, o_busy=0, o_press_cnt=0.
- Deassertion of i_rst_n is assumed synchronized externally; the first active edge after deassertion behaves as a normal edge.
- FSM has four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - i_sync=1 -> WAIT_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - i_sync=0 -> IDLE_LOW, cnt<=0; no output change.
  - i_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, cnt<=0, o_level<=1, o_rise<=1.
  - i_sync=1 otherwise -> cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW mirror IDLE_LOW and WAIT_HIGH with polarity inverted. The commit transition sets o_level<=0 and o_fall<=1.
- Net effect: o_level changes on the edge that samples the DEBOUNCE_CYCLES-th consecutive new value.
- Latency: i_sync changes before edge k -> o_level and pulse visible after edge k+DEBOUNCE_CYCLES-1.
- Glitch rejection: any run of the new value shorter than DEBOUNCE_CYCLES produces no output change. The counter restarts from 0 on the first sample of the old value.
- Pulses: o_rise and o_fall are high for exactly one cycle, never both in the same cycle, and are 0 on every non-commit edge.
- Minimum spacing between a rise and the following fall is DEBOUNCE_CYCLES cycles.
- o_busy = (state==WAIT_HIGH) or (state==WAIT_LOW).
- Press counter:
  - Increments on each rise commit (same edge that sets o_rise).
  - Saturates at 2**EVT_W-1; no wrap.
  - i_clr_cnt=1 alone -> 0.
  - i_clr_cnt=1 and a rise commit on the same edge -> 1; the press is not lost.
  - i_clr_cnt at saturation with a coincident commit -> 1.
- Reset asserted mid-WAIT: the in-progress candidate is discarded and all outputs return to reset values immediately.
- Reset while i_sync=1: after release the block starts in IDLE_LOW and needs DEBOUNCE_CYCLES samples of 1 to raise o_level; o_rise fires at that commit.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1; no arithmetic overflow is possible given the CNT_W constraint.

Test Plan:
(All with DEBOUNCE_CYCLES=4, EVT_W=8.)
1. Clean press: reset, hold i_sync=0 for 5 cycles, then i_sync=1 sampled at edges 10..20 -> o_busy=1 after edges 10..12; o_level=1 and o_rise=1 after edge 13 only; o_press_cnt=1; o_busy=0 after edge 13.
2. Glitch rejection: i_sync=1 for 3 edges then 0 -> o_level stays 0, no o_rise, o_press_cnt unchanged, o_busy drops the edge after the 0 is sampled.
3. Bounce then settle: pattern 1,1,0,1,1,1,1 from the low state -> commit on the 4th consecutive 1 (7th sample); exactly one o_rise; a subsequent 0 held for 4 edges -> exactly one o_fall, o_level=0.
4. Saturation: 256 clean press/release cycles -> o_press_cnt=255 and stays 255; then i_clr_cnt=1 coincident with the next rise commit -> o_press_cnt=1.
5. Reset mid-operation: assert i_rst_n=0 asynchronously between edges while in WAIT_HIGH with cnt=2 -> all outputs 0 immediately, without a clock edge; release with i_sync=1 held -> o_rise appears 4 edges later.
6. Pulse exclusivity: random i_sync stream of 10k cycles, checked against a reference model -> o_rise and o_fall never both high, each pulse is one cycle wide, and o_level always equals the model.
